// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the rv32i core, with retired-instruction counter.
// Optional illegal-instruction trap is compiled in with `define ILLEGAL_TRAP_EN.
module core_seq_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_load,
  input  logic        is_lui,
  input  logic        is_i_type,
  input  logic        is_i_load_type,
  input  logic        is_branch,
  input  logic        is_store,
  input  logic [3:0]  alu_ops,
  input  logic        alu_pc_load,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        retire,
  output logic [31:0] instret,
  output logic [2:0]  state,
  output logic        trap
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

  state_t      state_r, state_nx_s;
  logic [3:0]  exec_cnt_r, exec_cnt_nx_s;
  logic [31:0] instret_r;
  logic        run_r;
  logic        class_none_s, muldiv_s, mem_op_s;
  logic        imem_req_s, dmem_req_s, dmem_we_s, rf_we_s, pc_we_s, pc_sel_s, retire_s;

`ifdef ILLEGAL_TRAP_EN
  logic        trap_s;

  function automatic logic op_legal(input logic [4:0] cls, input logic [3:0] op);
    logic ok;
    case (cls)
      5'b00000: ok = (op <= 4'b0110) || (op == 4'b1001) || (op == 4'b1100) ||
                     (op == 4'b1101) || (op == 4'b1110);
      5'b01000: ok = (op == 4'b0000) || (op == 4'b0010) || (op == 4'b1000) || (op == 4'b1011);
      5'b00010: ok = (op <= 4'b0011) || (op == 4'b0110);
      5'b10000: ok = 1'b1;
      5'b00100: ok = 1'b1;
      5'b00001: ok = 1'b1;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  assign class_none_s = ~(is_lui | is_i_type | is_i_load_type | is_branch | is_store);
  assign muldiv_s     = class_none_s &&
                        ((alu_ops == 4'b1100) || (alu_ops == 4'b1101) || (alu_ops == 4'b1110));
  assign mem_op_s     = is_i_load_type | is_store;

  // Next-state, exec counter and state-decoded controls
  always_comb begin
    state_nx_s    = state_r;
    exec_cnt_nx_s = exec_cnt_r;
    imem_req_s    = 1'b0;
    dmem_req_s    = 1'b0;
    dmem_we_s     = 1'b0;
    rf_we_s       = 1'b0;
    pc_we_s       = 1'b0;
    pc_sel_s      = 1'b0;
    retire_s      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    trap_s        = 1'b0;
`endif
    case (state_r)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ack) begin
          state_nx_s = S_DECODE;
        end else begin
          state_nx_s = S_FETCH;
        end
      end
      S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        if (!op_legal({is_lui, is_i_type, is_i_load_type, is_branch, is_store}, alu_ops)) begin
          state_nx_s    = S_TRAP;
          exec_cnt_nx_s = 4'd0;
        end else begin
          state_nx_s    = S_EXEC;
          exec_cnt_nx_s = muldiv_s ? MD_LOAD : 4'd0;
        end
`else
        state_nx_s    = S_EXEC;
        exec_cnt_nx_s = muldiv_s ? MD_LOAD : 4'd0;
`endif
      end
      S_EXEC: begin
        if (exec_cnt_r == 4'd0) begin
          state_nx_s = mem_op_s ? S_MEM : S_WB;
        end else begin
          exec_cnt_nx_s = exec_cnt_r - 4'd1;
          state_nx_s    = S_EXEC;
        end
      end
      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = is_store;
        if (dmem_ack) begin
          // A store retires on its ack cycle; a load still has writeback ahead
          if (is_store) begin
            pc_we_s    = 1'b1;
            retire_s   = 1'b1;
            state_nx_s = S_FETCH;
          end else begin
            state_nx_s = S_WB;
          end
        end else begin
          state_nx_s = S_MEM;
        end
      end
      S_WB: begin
        pc_we_s    = 1'b1;
        retire_s   = 1'b1;
        rf_we_s    = ~is_store & (~is_branch | (alu_ops == 4'b0110));
        pc_sel_s   = is_branch & alu_pc_load;
        state_nx_s = S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        trap_s     = 1'b1;
        state_nx_s = S_TRAP;
`else
        state_nx_s = S_FETCH;
`endif
      end
      default: begin
        state_nx_s = S_FETCH;
      end
    endcase
  end

  // run_r keeps every control low until the first edge after reset release
  assign imem_req = run_r & imem_req_s;
  assign ir_load  = run_r & (state_r == S_FETCH) & imem_ack;
  assign dmem_req = run_r & dmem_req_s;
  assign dmem_we  = run_r & dmem_we_s;
  assign rf_we    = run_r & rf_we_s;
  assign pc_we    = run_r & pc_we_s;
  assign pc_sel   = run_r & pc_sel_s;
  assign retire   = run_r & retire_s;
  assign instret  = instret_r;
  assign state    = state_r;
`ifdef ILLEGAL_TRAP_EN
  assign trap     = run_r & trap_s;
`else
  assign trap     = 1'b0;
`endif

  // State, exec counter, run flag and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_FETCH;
      exec_cnt_r <= 4'd0;
      instret_r  <= 32'd0;
      run_r      <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (run_r) begin
        state_r    <= state_nx_s;
        exec_cnt_r <= exec_cnt_nx_s;
      end else begin
        state_r    <= state_r;
        exec_cnt_r <= exec_cnt_r;
      end
      if (retire) begin
        instret_r <= instret_r + 32'd1;
      end else begin
        instret_r <= instret_r;
      end
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: per-cycle expected traces built from instruction timing rules.
module tb_core_seq_ctrl;
  localparam int M = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack, ir_load;
  logic        is_lui, is_i_type, is_i_load_type, is_branch, is_store;
  logic [3:0]  alu_ops;
  logic        alu_pc_load;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        rf_we, pc_we, pc_sel, retire, trap;
  logic [31:0] instret;
  logic [2:0]  state;

  always #5 clk = ~clk;

  core_seq_ctrl #(.MULDIV_CYCLES(M)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
    .is_lui(is_lui), .is_i_type(is_i_type), .is_i_load_type(is_i_load_type),
    .is_branch(is_branch), .is_store(is_store), .alu_ops(alu_ops), .alu_pc_load(alu_pc_load),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .retire(retire), .instret(instret), .state(state), .trap(trap)
  );

  // ctl = {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire, trap}
  typedef struct packed { logic [8:0] ctl; logic [2:0] st; logic [31:0] ir; } exp_t;
  typedef struct packed { logic ia; logic da; exp_t e; } step_t;

  step_t trace[$];
  exp_t  exp_r;
  logic  exp_v = 1'b0;
  int    checks = 0;
  int    passes = 0;
  int    model_instret = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    else passes++;
  endtask

  function automatic exp_t mk(input logic [8:0] c, input logic [2:0] s);
    exp_t e;
    e.ctl = c;
    e.st  = s;
    e.ir  = 32'(model_instret);
    return e;
  endfunction

`ifdef ILLEGAL_TRAP_EN
  function automatic logic legal(input logic [4:0] fl, input logic [3:0] op);
    if ($countones(fl) > 1) return 1'b0;
    if (fl == 5'b00000) return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd12, 4'd13, 4'd14};
    if (fl == 5'b01000) return op inside {4'd0, 4'd2, 4'd8, 4'd11};
    if (fl == 5'b00010) return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6};
    return 1'b1;
  endfunction
`endif

  // fl = {lui, i_type, load, branch, store}; builds the expected cycle-by-cycle trace of one instruction
  task automatic build(input logic [4:0] fl, input logic [3:0] ops, input logic pcl,
                       input int iw, input int dw, input logic spur);
    logic ld, st, br, muldiv;
    int   n_exec;
    ld = fl[2]; st = fl[0]; br = fl[1];
    muldiv = (fl == 5'b00000) && (ops inside {4'd12, 4'd13, 4'd14});
    trace.delete();
    for (int i = 0; i < iw; i++) trace.push_back({1'b0, spur, mk(9'b100000000, 3'd0)});
    trace.push_back({1'b1, spur, mk(9'b110000000, 3'd0)});
    trace.push_back({spur, spur, mk(9'b000000000, 3'd1)});
`ifdef ILLEGAL_TRAP_EN
    if (!legal(fl, ops)) begin
      for (int i = 0; i < 5; i++) trace.push_back({spur, spur, mk(9'b000000001, 3'd5)});
      return;
    end
`endif
    n_exec = muldiv ? M : 1;
    for (int i = 0; i < n_exec; i++) trace.push_back({spur, spur, mk(9'b000000000, 3'd2)});
    if (ld || st) begin
      for (int i = 0; i < dw; i++) trace.push_back({spur, 1'b0, mk({3'b001, st, 5'b00000}, 3'd3)});
      trace.push_back({spur, 1'b1, mk({3'b001, st, 1'b0, st, 1'b0, st, 1'b0}, 3'd3)});
      if (st) begin
        model_instret++;
        return;
      end
    end
    trace.push_back({spur, spur, mk({4'b0000, (~br | (ops == 4'd6)), 1'b1, (br & pcl), 1'b1, 1'b0}, 3'd4)});
    model_instret++;
  endtask

  task automatic play(input logic [4:0] fl, input logic [3:0] ops, input logic pcl, input int upto);
    int n;
    n = (upto < 0) ? trace.size() : upto;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      {is_lui, is_i_type, is_i_load_type, is_branch, is_store} = fl;
      alu_ops     = ops;
      alu_pc_load = pcl;
      imem_ack    = trace[i].ia;
      dmem_ack    = trace[i].da;
      exp_r       = trace[i].e;
      exp_v       = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    model_instret = 0;
    exp_r = '0; exp_v = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  // Single compare point: all DUT outputs against the current expected cycle
  always @(negedge clk) begin
    if (exp_v) begin
      chk("ctl", 64'({imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire, trap}),
          64'(exp_r.ctl));
      chk("state", 64'(state), 64'(exp_r.st));
      chk("instret", 64'(instret), 64'(exp_r.ir));
    end
  end

  initial begin
    imem_ack = 1'b0; dmem_ack = 1'b0; alu_ops = 4'd0; alu_pc_load = 1'b0;
    {is_lui, is_i_type, is_i_load_type, is_branch, is_store} = 5'b00000;
    #1; exp_r = '0; exp_v = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    build(5'b00000, 4'b0000, 1'b0, 2, 0, 1'b0);   // ADD, fetch ack after 2 waits
    chk("add_len", 64'(trace.size()), 64'd6);
    play(5'b00000, 4'b0000, 1'b0, -1);
    build(5'b00000, 4'b1100, 1'b0, 0, 0, 1'b0);   // MUL
    chk("mul_len", 64'(trace.size()), 64'd7);
    play(5'b00000, 4'b1100, 1'b0, -1);
    build(5'b00100, 4'b0000, 1'b0, 0, 3, 1'b0);   // load, 3 wait cycles
    chk("load_len", 64'(trace.size()), 64'd8);
    play(5'b00100, 4'b0000, 1'b0, -1);
    build(5'b00001, 4'b0000, 1'b0, 0, 3, 1'b0);   // store, 3 wait cycles
    chk("store_len", 64'(trace.size()), 64'd7);
    play(5'b00001, 4'b0000, 1'b0, -1);
    build(5'b00010, 4'b0000, 1'b1, 1, 0, 1'b0);   // BEQ taken
    play(5'b00010, 4'b0000, 1'b1, -1);
    build(5'b00010, 4'b0110, 1'b1, 0, 0, 1'b0);   // JAL
    play(5'b00010, 4'b0110, 1'b1, -1);
    build(5'b00010, 4'b0001, 1'b0, 0, 0, 1'b0);   // BNE not taken
    play(5'b00010, 4'b0001, 1'b0, -1);
    build(5'b10000, 4'b0000, 1'b0, 0, 0, 1'b1);   // LUI with spurious acks
    play(5'b10000, 4'b0000, 1'b0, -1);
    build(5'b01000, 4'b0010, 1'b0, 1, 0, 1'b1);   // I-type with spurious acks
    play(5'b01000, 4'b0010, 1'b0, -1);
    build(5'b00100, 4'b0000, 1'b0, 0, 2, 1'b1);   // load with spurious imem_ack in MEM
    play(5'b00100, 4'b0000, 1'b0, -1);
    chk("model_cnt", 64'(model_instret), 64'd10);
    build(5'b00000, 4'b0111, 1'b0, 0, 0, 1'b0);   // R-type 0111
`ifdef ILLEGAL_TRAP_EN
    chk("model_trap_cnt", 64'(model_instret), 64'd10);
`else
    chk("model_ill_cnt", 64'(model_instret), 64'd11);
`endif
    play(5'b00000, 4'b0111, 1'b0, -1);

    // Reset in the middle of a MUL execute phase
    build(5'b00000, 4'b1101, 1'b0, 0, 0, 1'b0);
    play(5'b00000, 4'b1101, 1'b0, 4);
    do_reset();
    build(5'b00000, 4'b0000, 1'b0, 0, 0, 1'b0);
    play(5'b00000, 4'b0000, 1'b0, -1);
    @(posedge clk); #1;
    exp_v = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    chk("final_instret", 64'(instret), 64'd1);
    chk("final_fetch", 64'({imem_req, state}), 64'({1'b1, 3'd0}));
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
